// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//    Types shared by the CPU memory-side blocks.
//    word_t     : 32-bit data/address word
//    ramstate_t : RAM handshake state returned by the memory model/controller
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// diaosi_types_pkg
//    Types and constants for the atomic-capable data memory responder.
//    dstate_t   : responder FSM state
//    ERR_LOAD   : load value returned when an access errors or times out
//    word_align : clears the byte-offset bits of an address
package diaosi_types_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      READ   = 3'd1,
      WRITE  = 3'd2,
      SCFAIL = 3'd3,
      DONE   = 3'd4
   } dstate_t;

   localparam cpu_types_pkg::word_t ERR_LOAD = 32'hBAD1_BAD1;

   function automatic cpu_types_pkg::word_t word_align(input cpu_types_pkg::word_t a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/llsc_link_reg.sv
// llsc_link_reg
//    LL/SC reservation register {link_valid, link_addr}.
//    Ports:
//       CLK, RST    : clock, synchronous active-high reset
//       set         : LL completed; reserve set_addr (word aligned)
//       set_addr    : address to reserve
//       clear       : unconditional kill (successful SC)
//       wr_hit      : a write completed at wr_addr; kills on address match
//       wr_addr     : completed write address (word aligned)
//       snoop       : external invalidate
//       snoop_addr  : invalidate address (byte address, compared per word)
//       query_addr  : word-aligned SC address being checked this cycle
//       match       : reservation valid, equal to query_addr, and not being
//                     snooped away this very cycle
module llsc_link_reg
   import cpu_types_pkg::*, diaosi_types_pkg::*;
(
   input  logic  CLK,
   input  logic  RST,
   input  logic  set,
   input  word_t set_addr,
   input  logic  clear,
   input  logic  wr_hit,
   input  word_t wr_addr,
   input  logic  snoop,
   input  word_t snoop_addr,
   input  word_t query_addr,
   output logic  match
);

   logic  link_valid;
   word_t link_addr;
   logic  snoop_kill;
   logic  snoop_on_set;

   assign snoop_kill   = snoop && (word_align(snoop_addr) == link_addr);
   assign snoop_on_set = snoop && (word_align(snoop_addr) == set_addr);

   // A snoop landing in the SC acceptance cycle must already fail the check.
   assign match = link_valid && (link_addr == query_addr) && !snoop_kill;

   always_ff @(posedge CLK) begin
      if (RST) begin
         link_valid <= 1'b0;
         link_addr  <= '0;
      end else if (set) begin
         // A snoop to the address being reserved in the same cycle wins.
         link_addr  <= set_addr;
         link_valid <= !snoop_on_set;
      end else if (clear || snoop_kill || (wr_hit && (wr_addr == link_addr))) begin
         link_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/dmem_atomic_responder.sv
// dmem_atomic_responder
//    Data-memory responder with LL/SC support. Accepts one load/store from
//    the CPU side, runs it against the RAM handshake, and returns a one-cycle
//    dhit with load data (or the SC result: 1 pass, 0 fail).
//    Ports:
//       CLK, RST            : clock, synchronous active-high reset
//       dmemREN, dmemWEN    : CPU load / store request (store has priority)
//       datomic             : request is LL (with REN) or SC (with WEN)
//       dmemaddr, dmemstore : CPU address and store data
//       dhit                : one-cycle completion pulse
//       dmemload            : load data / SC result / ERR_LOAD on error
//       ramREN, ramWEN      : RAM read/write strobes (Moore)
//       ramaddr, ramstore   : latched word-aligned address and store data
//       ramload, ramstate   : RAM read data and handshake state
//       snoop_inv/addr      : external reservation invalidate
//       err                 : sticky error flag (RAM ERROR or timeout)
module dmem_atomic_responder
   import cpu_types_pkg::*, diaosi_types_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
)
(
   input  logic      CLK,
   input  logic      RST,
   input  logic      dmemREN,
   input  logic      dmemWEN,
   input  logic      datomic,
   input  word_t     dmemaddr,
   input  word_t     dmemstore,
   output logic      dhit,
   output word_t     dmemload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   input  logic      snoop_inv,
   input  word_t     snoop_addr,
   output logic      err
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   dstate_t       state, next_state;
   logic          atomic_q;
   logic [CW-1:0] count;
   word_t         req_addr;

   logic  accept;
   logic  sc_ok;
   logic  ll_set;
   logic  sc_clear;
   logic  wr_hit;
   logic  load_en;
   word_t load_val;
   logic  err_set;
   logic  wait_expired;

   assign req_addr     = word_align(dmemaddr);
   assign wait_expired = (ramstate == ERROR) || (count == CNT_LAST);

   assign ramREN = (state == READ);
   assign ramWEN = (state == WRITE);
   assign dhit   = (state == DONE);

   llsc_link_reg u_link (
      .CLK        (CLK),
      .RST        (RST),
      .set        (ll_set),
      .set_addr   (ramaddr),
      .clear      (sc_clear),
      .wr_hit     (wr_hit),
      .wr_addr    (ramaddr),
      .snoop      (snoop_inv),
      .snoop_addr (snoop_addr),
      .query_addr (req_addr),
      .match      (sc_ok)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      ll_set     = 1'b0;
      sc_clear   = 1'b0;
      wr_hit     = 1'b0;
      load_en    = 1'b0;
      load_val   = '0;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            if (dmemWEN) begin
               accept     = 1'b1;
               next_state = (datomic && !sc_ok) ? SCFAIL : WRITE;
            end else if (dmemREN) begin
               accept     = 1'b1;
               next_state = READ;
            end
         end
         READ: begin
            if (ramstate == ACCESS) begin
               next_state = DONE;
               load_en    = 1'b1;
               load_val   = ramload;
               ll_set     = atomic_q;
            end else if (wait_expired) begin
               next_state = DONE;
               load_en    = 1'b1;
               load_val   = ERR_LOAD;
               err_set    = 1'b1;
            end
         end
         WRITE: begin
            if (ramstate == ACCESS) begin
               next_state = DONE;
               wr_hit     = 1'b1;
               sc_clear   = atomic_q;
               load_en    = atomic_q;
               load_val   = 32'd1;
            end else if (wait_expired) begin
               // A passed SC gives up its reservation even if the write fails.
               next_state = DONE;
               sc_clear   = atomic_q;
               load_en    = 1'b1;
               load_val   = ERR_LOAD;
               err_set    = 1'b1;
            end
         end
         SCFAIL: begin
            next_state = DONE;
            load_en    = 1'b1;
            load_val   = '0;
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ramaddr  <= '0;
         ramstore <= '0;
         atomic_q <= 1'b0;
         count    <= '0;
         dmemload <= '0;
         err      <= 1'b0;
      end else begin
         if (accept) begin
            ramaddr  <= req_addr;
            ramstore <= dmemstore;
            atomic_q <= datomic;
            count    <= '0;
         end else if ((state == READ) || (state == WRITE)) begin
            count <= count + 1'b1;
         end
         if (load_en) begin
            dmemload <= load_val;
         end
         if (err_set) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/dmem_atomic_responder.md
DMEM_ATOMIC_RESPONDER -- requirements
Module: dmem_atomic_responder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max RAM wait cycles per access before error completion.
REQ-002 SHALL have ports CLK in 1 clock; RST in 1 reset, synchronous, active-high; one clock domain only.
REQ-003 SHALL have dmemREN in 1 load request; dmemWEN in 1 store request; datomic in 1 LL/SC qualifier; dmemaddr in word_t; dmemstore in word_t.
REQ-004 SHALL have dhit out 1 completion pulse; dmemload out word_t load data or SC result.
REQ-005 SHALL have ramREN out 1; ramWEN out 1; ramaddr out word_t; ramstore out word_t; ramload in word_t; ramstate in ramstate_t (FREE, BUSY, ACCESS, ERROR).
REQ-006 SHALL have snoop_inv in 1 and snoop_addr in word_t for external reservation kill; err out 1 sticky error flag.

Function
REQ-007 SHALL implement FSM states IDLE, READ, WRITE, SCFAIL, DONE.
REQ-008 IDLE: dmemWEN=1 -> WRITE (or SCFAIL when datomic=1 and the SC check fails); else dmemREN=1 -> READ; dmemWEN has priority when both are set.
REQ-009 On acceptance SHALL latch addr as {dmemaddr[31:2],2'b00} and dmemstore; ramaddr and ramstore SHALL hold these latched values until DONE.
REQ-010 ramREN SHALL be 1 only in READ; ramWEN SHALL be 1 only in WRITE; both are Moore outputs.
REQ-011 READ/WRITE: ramstate==ACCESS -> DONE; in READ, ramload SHALL be registered into dmemload; in WRITE with datomic set, dmemload SHALL be set to 1.
REQ-012 SCFAIL SHALL issue no RAM access, set dmemload=0, and go to DONE on the next cycle.
REQ-013 DONE SHALL assert dhit for exactly one cycle, then go to IDLE; requests SHALL NOT be sampled while in DONE.
REQ-014 Minimum latency SHALL be 3 cycles from request sample to dhit (IDLE, READ/WRITE with ACCESS, DONE); SCFAIL latency SHALL be 3 cycles.
REQ-015 A wait counter SHALL clear on acceptance and increment each cycle in READ/WRITE; ramstate==ERROR, or count==TIMEOUT-1 without ACCESS, -> DONE with dmemload=32'hBAD1BAD1 and err set.
REQ-016 Reservation = {link_valid, link_addr}; a completed LL read (READ with datomic and ACCESS) SHALL set link_valid=1 and link_addr=latched addr.
REQ-017 SC check passes iff link_valid and link_addr equals the incoming word-aligned address, both evaluated in the IDLE acceptance cycle.
REQ-018 Any completed write (SW, or SC that passed) to link_addr SHALL clear link_valid; an SC that passed SHALL always clear link_valid.
REQ-019 snoop_inv with snoop_addr word-matching link_addr SHALL clear link_valid in that cycle.
REQ-020 Snoop in the same cycle as an LL set to the same address: clear wins; snoop in the SC acceptance cycle: SC fails.
REQ-021 err SHALL remain set until RST.

Reset
REQ-022 On RST SHALL: state=IDLE; dhit=0; dmemload=0; ramREN=0; ramWEN=0; ramaddr=0; ramstore=0; link_valid=0; link_addr=0; counter=0; err=0.
REQ-023 RST asserted mid-access SHALL abort the access at the next edge with no dhit; the pending request SHALL be re-sampled only after RST deasserts.

Structure
REQ-024 The FSM state enum SHALL reside in diaosi_types_pkg; word_t and ramstate_t SHALL come from cpu_types_pkg.
REQ-025 The reservation SHALL be the sub-module llsc_link_reg (set, clear, snoop, match ports); the FSM and counter SHALL be in the top module.

Verification
REQ-026 LW 0x104, ramstate ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> ramaddr=0x104, dhit at cycle 5, dmemload=0xDEADBEEF.
REQ-027 LL 0x200, then SC 0x200 with data 0x55 -> ramWEN pulse with ramstore=0x55, dmemload=1, link_valid=0 afterwards.
REQ-028 LL 0x200, snoop_inv 0x200, SC 0x200 -> no ramWEN, dmemload=0, dhit 3 cycles after the request.
REQ-029 LL 0x200, SW 0x203, SC 0x200 -> SW clears link_valid (aligned match), SC fails with dmemload=0.
REQ-030 TIMEOUT=4, ramstate stuck BUSY on LW -> dhit after 4 wait cycles, dmemload=0xBAD1BAD1, err=1 persistent.
REQ-031 RST during WRITE wait -> ramWEN=0 next cycle, no dhit, link_valid=0, state IDLE.
